// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Bundle of the ALU operand/result signals used by the execute-stage side
// (master) and the ALU side (slave). The ALU itself keeps flat ports so the
// execute stage can connect it positionally; this bundle groups the same
// signals for whoever drives or observes the ALU.
//
// Signals:
//   A, B    64-bit signed operands (A = valB, B = valA)
//   ctrl    2-bit op select: 00 add, 01 sub, 10 and, 11 xor
//   set_cc  load enable for the condition-code register
//   ans     64-bit signed result (combinational)
//   cond    combinational flags {ZF, SF, OF}
//   cc      registered flags {ZF, SF, OF}
// -----------------------------------------------------------------------------
interface alu_if;
  logic signed [63:0] A;
  logic signed [63:0] B;
  logic        [1:0]  ctrl;
  logic               set_cc;
  logic signed [63:0] ans;
  logic        [2:0]  cond;
  logic        [2:0]  cc;

  modport master (
    output A, B, ctrl, set_cc,
    input  ans, cond, cc
  );

  modport slave (
    input  A, B, ctrl, set_cc,
    output ans, cond, cc
  );
endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// 64-bit combinational ALU for the Y86-64 SEQ execute stage plus a 3-bit
// condition-code register. Performs add, sub (A - B, i.e. valB - valA), and,
// xor, and produces the flags {ZF, SF, OF}. Add and sub share one ripple-carry
// adder built from 1-bit full-adder cells; B is inverted and the carry-in set
// for sub. The adder carry-out is dropped (Y86 has no carry flag).
//
// Ports (declaration order fixed for positional hookup):
//   A       in  64  signed operand A (valB)
//   B       in  64  signed operand B (valA)
//   ctrl    in  2   00 add, 01 sub, 10 and, 11 xor
//   ans     out 64  signed result, combinational
//   cond    out 3   combinational flags [2]=ZF [1]=SF [0]=OF
//   clock   in  1   rising-edge clock for the CC register
//   reset   in  1   synchronous active-high reset of the CC register (-> 3'b100)
//   set_cc  in  1   load cond into the CC register on the next rising edge
//   cc      out 3   registered flags, same layout as cond
//
// Configuration macro: ALU_CC_REG_EN
//   defined   : cc is a register (reset has priority over set_cc)
//   undefined : cc is wired straight to cond; clock/reset/set_cc are ignored
// -----------------------------------------------------------------------------

// 1-bit full-adder cell used to build the ripple-carry adder.
module alu_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module alu (
  input  logic signed [63:0] A,
  input  logic signed [63:0] B,
  input  logic        [1:0]  ctrl,
  output logic signed [63:0] ans,
  output logic        [2:0]  cond,
  input  logic               clock,
  input  logic               reset,
  input  logic               set_cc,
  output logic        [2:0]  cc
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  localparam logic [2:0] CC_RESET = 3'b100;

  alu_op_e     w_op;
  logic        w_sub;
  logic [63:0] w_b_in;
  logic [64:0] w_carry;
  logic [63:0] w_sum;
  logic        w_zf;
  logic        w_sf;
  logic        w_of;

  assign w_op  = alu_op_e'(ctrl);
  assign w_sub = (w_op == OP_SUB);

  // Subtraction as A + ~B + 1: invert B and inject the +1 as carry-in.
  assign w_b_in     = B ^ {64{w_sub}};
  assign w_carry[0] = w_sub;

  for (genvar i = 0; i < 64; i++) begin : g_rca
    alu_fa u_fa (
      .i_a (A[i]),
      .i_b (w_b_in[i]),
      .i_c (w_carry[i]),
      .o_s (w_sum[i]),
      .o_c (w_carry[i+1])
    );
  end

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ans  = '0;
    w_of = 1'b0;
    unique case (w_op)
      OP_ADD: begin
        ans  = w_sum;
        w_of = (A[63] == B[63]) && (w_sum[63] != A[63]);
      end
      OP_SUB: begin
        ans  = w_sum;
        // Overflow of A - B: operands of opposite sign and result sign
        // differs from A.
        w_of = (A[63] != B[63]) && (w_sum[63] != A[63]);
      end
      OP_AND: ans = A & B;
      OP_XOR: ans = A ^ B;
      default: ;
    endcase
  end

  assign w_zf = (ans == 64'd0);
  assign w_sf = ans[63];
  assign cond = {w_zf, w_sf, w_of};

`ifdef ALU_CC_REG_EN
  logic [2:0] r_cc;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  // NOTE: reset is synchronous and checked first, so it overrides set_cc.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cc <= CC_RESET;
    end else if (set_cc) begin
      r_cc <= cond;
    end
  end

  assign cc = r_cc;

  // Adder carry-out has no consumer (no carry flag).
  logic w_unused;
  assign w_unused = w_carry[64];
`else
  // No register: cc mirrors cond, and the clocking inputs and the adder
  // carry-out are intentionally left without a consumer.
  assign cc = cond;

  logic w_unused;
  assign w_unused = &{1'b0, clock, reset, set_cc, w_carry[64], CC_RESET};
`endif

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Directed-vector bench for alu. Operands are driven on the falling edge,
// combinational outputs are sampled 1 ns later, and cc is sampled 1 ns after
// the following rising edge. Expected values are hand-computed constants.
// Works for both builds: expectations that depend on ALU_CC_REG_EN are
// selected with the same macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu;

  logic clock = 1'b0;
  logic reset = 1'b1;

  alu_if u_if ();

  alu dut (
    .A      (u_if.A),
    .B      (u_if.B),
    .ctrl   (u_if.ctrl),
    .ans    (u_if.ans),
    .cond   (u_if.cond),
    .clock  (clock),
    .reset  (reset),
    .set_cc (u_if.set_cc),
    .cc     (u_if.cc)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] op, input logic sc, input logic rst);
    @(negedge clock);
    u_if.A      = a;
    u_if.B      = b;
    u_if.ctrl   = op;
    u_if.set_cc = sc;
    reset       = rst;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic [63:0] ans;
    logic [2:0]  cond;
  } vec_t;

  vec_t vecs[10];

  logic [2:0] exp_hold;

  initial begin
    vecs[0] = '{"add_ovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 64'h8000_0000_0000_0000, 3'b011};
    vecs[1] = '{"sub_zero",   64'd5, 64'd5, 2'b01, 64'h0, 3'b100};
    vecs[2] = '{"sub_neg",    64'd3, 64'd5, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010};
    vecs[3] = '{"sub_ovf",    64'h8000_0000_0000_0000, 64'h1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
    vecs[4] = '{"and",        64'hF0F0, 64'hFF00, 2'b10, 64'hF000, 3'b000};
    vecs[5] = '{"xor",        64'hF0F0, 64'hFF00, 2'b11, 64'h0FF0, 3'b000};
    vecs[6] = '{"xor_self",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 64'h0, 3'b100};
    vecs[7] = '{"add_wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 64'h0, 3'b100};
    vecs[8] = '{"add_negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 64'h0, 3'b101};
    vecs[9] = '{"sub_posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011};

    // Reset for one edge with A=B=0 add: cc is 3'b100 in either build.
    drive(64'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    after_edge();
    check("reset_cc", {61'd0, u_if.cc}, 64'h4);

    // Main vectors with set_cc=1: combinational check, then cc after edge.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, 1'b0);
      check({vecs[i].tag, "_ans"},  u_if.ans, vecs[i].ans);
      check({vecs[i].tag, "_cond"}, {61'd0, u_if.cond}, {61'd0, vecs[i].cond});
      after_edge();
      check({vecs[i].tag, "_cc"},   {61'd0, u_if.cc}, {61'd0, vecs[i].cond});
    end

    // CC register sequence.
    drive(64'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    after_edge();
    check("seq_reset_cc", {61'd0, u_if.cc}, 64'h4);

    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b1, 1'b0);
`ifdef ALU_CC_REG_EN
    check("seq_pre_edge_cc", {61'd0, u_if.cc}, 64'h4);
`else
    check("seq_pre_edge_cc", {61'd0, u_if.cc}, 64'h3);
`endif
    after_edge();
    check("seq_load_cc", {61'd0, u_if.cc}, 64'h3);

    // Drop set_cc and present a zero result: registered cc holds.
`ifdef ALU_CC_REG_EN
    exp_hold = 3'b011;
`else
    exp_hold = 3'b100;
`endif
    drive(64'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    check("seq_hold_cond", {61'd0, u_if.cond}, 64'h4);
    after_edge();
    check("seq_hold_cc", {61'd0, u_if.cc}, {61'd0, exp_hold});

    // Reset together with set_cc while an overflowing sub is presented:
    // ans/cond keep following the inputs, cc goes to the reset value
    // (register build) or follows cond (wired build).
    drive(64'h8000_0000_0000_0000, 64'h1, 2'b01, 1'b1, 1'b1);
    check("seq_rst_ans",  u_if.ans, 64'h7FFF_FFFF_FFFF_FFFF);
    check("seq_rst_cond", {61'd0, u_if.cond}, 64'h1);
    after_edge();
`ifdef ALU_CC_REG_EN
    check("seq_rst_cc", {61'd0, u_if.cc}, 64'h4);
`else
    check("seq_rst_cc", {61'd0, u_if.cc}, 64'h1);
`endif

    drive(64'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
